// File: rtl/antitheft_timer.sv
// -----------------------------------------------------------------------------
// antitheft_timer
//
// Countdown timer and 1 Hz time base for the automotive anti-theft state
// machine. A start pulse loads one of four user-reprogrammable delay registers
// (selected by interval) into a seconds counter. The counter decrements on every
// 1 Hz tick. When the count reaches zero, expired is raised and held.
//
// Parameters:
//   CLK_FREQ          clock cycles per second (minimum 2)
//   T_ARM_DELAY       reset value of delay register 00 (seconds, 4-bit)
//   T_DRIVER_DELAY    reset value of delay register 01
//   T_PASSENGER_DELAY reset value of delay register 10
//   T_ALARM_ON        reset value of delay register 11
//
// Ports:
//   clock          in  system clock, rising edge
//   reset          in  asynchronous active-high reset
//   start_timer    in  one-cycle request to load and start the countdown
//   interval       in  [1:0] delay select, sampled with start_timer
//   reprogram      in  write strobe for the delay registers
//   time_param_sel in  [1:0] delay register written on reprogram
//   time_value     in  [3:0] value written on reprogram
//   one_hz_enable  out one-cycle pulse every CLK_FREQ cycles
//   expired        out level, delay completed; held until next start or reset
//   time_left      out [3:0] remaining seconds, 0 when idle
// -----------------------------------------------------------------------------
module antitheft_timer #(
  parameter int CLK_FREQ          = 50_000_000,
  parameter int T_ARM_DELAY       = 6,
  parameter int T_DRIVER_DELAY    = 8,
  parameter int T_PASSENGER_DELAY = 15,
  parameter int T_ALARM_ON        = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       one_hz_enable,
  output logic       expired,
  output logic [3:0] time_left
);

  localparam int                 PRESC_W  = $clog2(CLK_FREQ);
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_FREQ - 1);

  typedef enum logic {
    IDLE,
    RUNNING
  } state_t;

  logic [PRESC_W-1:0] presc;
  logic [3:0]         delay_reg [4];
  state_t             state;
  state_t             state_next;
  logic [3:0]         time_left_next;
  logic               expired_next;
  logic [3:0]         load_value;
  logic               running;

  // The tick is a decode of the prescaler register, so it is high for exactly
  // one cycle per period and has no path from the inputs.
  assign one_hz_enable = (presc == PRESC_TC);

  // Read before this edge's write lands, so a start and a reprogram of the same
  // register in one cycle loads the old value.
  assign load_value = delay_reg[interval];
  assign running    = (state == RUNNING);

  // Prescaler: free-running 0..CLK_FREQ-1. A start re-phases it so that the
  // first second after a start is a full CLK_FREQ cycles long.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (start_timer || one_hz_enable) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Delay registers: user-reprogrammable, independent of any countdown in
  // progress because the running count is held in time_left, not here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_reg[0] <= 4'(T_ARM_DELAY);
      delay_reg[1] <= 4'(T_DRIVER_DELAY);
      delay_reg[2] <= 4'(T_PASSENGER_DELAY);
      delay_reg[3] <= 4'(T_ALARM_ON);
    end else if (reprogram) begin
      delay_reg[time_param_sel] <= time_value;
    end
  end

  // Counter state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      time_left <= 4'd0;
      expired   <= 1'b0;
    end else begin
      state     <= state_next;
      time_left <= time_left_next;
      expired   <= expired_next;
    end
  end

  // Counter next-state logic. A start always takes priority over a tick. A
  // zero load skips RUNNING and reports expiry at the load edge. The 1->0 tick
  // both sets expired and drops back to IDLE, so a decrement from 0 never
  // happens.
  always_comb begin
    state_next     = state;
    time_left_next = time_left;
    expired_next   = expired;
    if (start_timer) begin
      if (load_value == 4'd0) begin
        state_next     = IDLE;
        time_left_next = 4'd0;
        expired_next   = 1'b1;
      end else begin
        state_next     = RUNNING;
        time_left_next = load_value;
        expired_next   = 1'b0;
      end
    end else if (running && one_hz_enable) begin
      if (time_left == 4'd1) begin
        state_next     = IDLE;
        time_left_next = 4'd0;
        expired_next   = 1'b1;
      end else begin
        time_left_next = time_left - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_antitheft_timer.sv
// -----------------------------------------------------------------------------
// tb_antitheft_timer
//
// Self-checking bench for antitheft_timer with CLK_FREQ=4. Each start pushes
// the expected number of edges from the start edge to expired onto a queue.
// The queue entry is popped and compared when expired is observed. Other
// checks are inline in each scenario task.
// -----------------------------------------------------------------------------
module tb_antitheft_timer;

  localparam int CLK_FREQ = 4;
  localparam int LIMIT    = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       expired;
  logic [3:0] time_left;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  antitheft_timer #(
    .CLK_FREQ         (CLK_FREQ),
    .T_ARM_DELAY      (6),
    .T_DRIVER_DELAY   (8),
    .T_PASSENGER_DELAY(15),
    .T_ALARM_ON       (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .interval      (interval),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .one_hz_enable (one_hz_enable),
    .expired       (expired),
    .time_left     (time_left)
  );

  always #5 clock = ~clock;

  // Start pulse sampled at the next rising edge; returns just after that edge.
  task automatic pulse_start(input logic [1:0] iv);
    @(negedge clock);
    interval    = iv;
    start_timer = 1'b1;
    @(posedge clock);
    #1;
    start_timer = 1'b0;
  endtask

  task automatic program_reg(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clock);
    time_param_sel = sel;
    time_value     = val;
    reprogram      = 1'b1;
    @(posedge clock);
    #1;
    reprogram = 1'b0;
  endtask

  // Counts edges until expired is seen, bounded; -1 means it never came.
  task automatic wait_expired(input int limit, output int edges);
    edges = 0;
    while (expired !== 1'b1 && edges < limit) begin
      @(posedge clock);
      #1;
      edges++;
    end
    if (expired !== 1'b1) edges = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_timer = 1'b0; interval = 2'd0;
    reprogram = 1'b0; time_param_sel = 2'd0; time_value = 4'd0;
    #3;
    tests_run++;
    if (one_hz_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick: got %b expected 0", one_hz_enable); end
    tests_run++;
    if (expired !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_expired: got %b expected 0", expired); end
    tests_run++;
    if (time_left !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_time_left: got %0d expected 0", time_left); end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic want_tick;
      @(posedge clock);
      #1;
      want_tick = ((k % CLK_FREQ) == CLK_FREQ - 1);
      tests_run++;
      if (one_hz_enable !== want_tick) begin tests_failed++; $display("[TB] FAIL idle_tick k=%0d: got %b expected %b", k, one_hz_enable, want_tick); end
      tests_run++;
      if (expired !== 1'b0 || time_left !== 4'd0) begin tests_failed++; $display("[TB] FAIL idle_outputs k=%0d: got exp=%b left=%0d expected 0/0", k, expired, time_left); end
    end
  endtask

  task automatic test_defaults;
    int secs [4] = '{6, 8, 15, 10};
    for (int i = 0; i < 4; i++) begin
      int edges;
      int want;
      exp_q.push_back(secs[i] * CLK_FREQ);
      pulse_start(2'(i));
      tests_run++;
      if (time_left !== 4'(secs[i])) begin tests_failed++; $display("[TB] FAIL default_load%0d: got %0d expected %0d", i, time_left, secs[i]); end
      wait_expired(LIMIT, edges);
      want = exp_q.pop_front();
      tests_run++;
      if (edges != want) begin tests_failed++; $display("[TB] FAIL default_expire%0d: got %0d edges expected %0d", i, edges, want); end
    end
  endtask

  task automatic test_driver_countdown;
    int edges;
    int want;
    exp_q.push_back(8 * CLK_FREQ);
    pulse_start(2'd1);
    for (int k = 0; k < 8 * CLK_FREQ; k++) begin
      tests_run++;
      if (time_left !== 4'(8 - k / CLK_FREQ) || expired !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL driver_count k=%0d: got left=%0d exp=%b expected left=%0d exp=0", k, time_left, expired, 8 - k / CLK_FREQ);
      end
      @(posedge clock);
      #1;
    end
    wait_expired(LIMIT, edges);
    want = exp_q.pop_front();
    tests_run++;
    if (edges < 0 || 8 * CLK_FREQ + edges != want) begin tests_failed++; $display("[TB] FAIL driver_expire: got %0d extra edges expected 0 past %0d", edges, want); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (expired !== 1'b1 || time_left !== 4'd0) begin tests_failed++; $display("[TB] FAIL driver_hold k=%0d: got exp=%b left=%0d expected 1/0", k, expired, time_left); end
    end
  endtask

  task automatic test_reprogram;
    int edges;
    int want;
    program_reg(2'd2, 4'd3);
    exp_q.push_back(3 * CLK_FREQ);
    pulse_start(2'd2);
    wait_expired(LIMIT, edges);
    want = exp_q.pop_front();
    tests_run++;
    if (edges != want) begin tests_failed++; $display("[TB] FAIL reprog3_expire: got %0d edges expected %0d", edges, want); end
    program_reg(2'd2, 4'd0);
    exp_q.push_back(0);
    pulse_start(2'd2);
    tests_run++;
    if (time_left !== 4'd0) begin tests_failed++; $display("[TB] FAIL zero_time_left: got %0d expected 0", time_left); end
    wait_expired(LIMIT, edges);
    want = exp_q.pop_front();
    tests_run++;
    if (edges != want) begin tests_failed++; $display("[TB] FAIL zero_expire: got %0d edges expected %0d", edges, want); end
  endtask

  task automatic test_restart;
    int edges;
    int want;
    pulse_start(2'd3);
    tests_run++;
    if (time_left !== 4'd10) begin tests_failed++; $display("[TB] FAIL restart_first_load: got %0d expected 10", time_left); end
    for (int k = 1; k < 20; k++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (expired !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_no_expire k=%0d: got %b expected 0", k, expired); end
    end
    exp_q.push_back(6 * CLK_FREQ);
    pulse_start(2'd0);
    tests_run++;
    if (time_left !== 4'd6 || expired !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_load: got left=%0d exp=%b expected 6/0", time_left, expired); end
    wait_expired(LIMIT, edges);
    want = exp_q.pop_front();
    tests_run++;
    if (edges != want) begin tests_failed++; $display("[TB] FAIL restart_expire: got %0d edges expected %0d", edges, want); end
  endtask

  task automatic test_start_with_write;
    int edges;
    int want;
    @(negedge clock);
    interval       = 2'd0;
    start_timer    = 1'b1;
    time_param_sel = 2'd0;
    time_value     = 4'd2;
    reprogram      = 1'b1;
    exp_q.push_back(6 * CLK_FREQ);
    @(posedge clock);
    #1;
    start_timer = 1'b0;
    reprogram   = 1'b0;
    tests_run++;
    if (time_left !== 4'd6) begin tests_failed++; $display("[TB] FAIL same_cycle_load: got %0d expected 6", time_left); end
    wait_expired(LIMIT, edges);
    want = exp_q.pop_front();
    tests_run++;
    if (edges != want) begin tests_failed++; $display("[TB] FAIL same_cycle_expire: got %0d edges expected %0d", edges, want); end
    exp_q.push_back(2 * CLK_FREQ);
    pulse_start(2'd0);
    tests_run++;
    if (time_left !== 4'd2) begin tests_failed++; $display("[TB] FAIL new_value_load: got %0d expected 2", time_left); end
    wait_expired(LIMIT, edges);
    want = exp_q.pop_front();
    tests_run++;
    if (edges != want) begin tests_failed++; $display("[TB] FAIL new_value_expire: got %0d edges expected %0d", edges, want); end
  endtask

  task automatic test_reset_midcount;
    pulse_start(2'd1);
    repeat (9) @(posedge clock);
    #1;
    tests_run++;
    if (time_left !== 4'd6) begin tests_failed++; $display("[TB] FAIL mid_count_before_reset: got %0d expected 6", time_left); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (time_left !== 4'd0 || expired !== 1'b0 || one_hz_enable !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got left=%0d exp=%b tick=%b expected 0/0/0", time_left, expired, one_hz_enable);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (expired !== 1'b0 || time_left !== 4'd0) begin tests_failed++; $display("[TB] FAIL post_reset_idle k=%0d: got exp=%b left=%0d expected 0/0", k, expired, time_left); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_driver_countdown();
    test_reprogram();
    test_restart();
    test_start_with_write();
    test_reset_midcount();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
